// File: rtl/serial_fifo_bridge_pkg.sv
// Shared types and defaults for the serial FIFO bridge.
// TX drain FSM encoding plus default FIFO geometry.
package serial_fifo_bridge_pkg;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;
endpackage

// File: rtl/sync_byte_fifo.sv
// Show-ahead single-clock FIFO with separate occupancy count.
// A push on full is accepted only when a pop frees a slot that cycle.
module sync_byte_fifo
  import serial_fifo_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; empty gates the read data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/serial_fifo_bridge.sv
// Byte buffering between the UART rx/tx pair and serial_ctrl.
// RX FIFO with sticky overflow; TX FIFO drained by a start/busy FSM.
module serial_fifo_bridge
  import serial_fifo_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxdReady_i,
  input  logic [DATA_WIDTH-1:0] rxdData_i,
  input  logic                  rxPop_i,
  output logic [DATA_WIDTH-1:0] rxData_o,
  output logic                  rxValid_o,
  output logic [DEPTH_LOG2:0]   rxCount_o,
  output logic                  rxOverflow_o,
  input  logic                  ovfClear_i,
  input  logic                  txPush_i,
  input  logic [DATA_WIDTH-1:0] txData_i,
  output logic                  txFull_o,
  output logic [DEPTH_LOG2:0]   txCount_o,
  input  logic                  txdBusy_i,
  output logic                  txdStart_o,
  output logic [DATA_WIDTH-1:0] txdData_o,
  output logic                  int_o
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic                  rx_full;
  logic                  rx_empty;
  logic                  ovf_set;
  logic                  tx_empty;
  logic                  tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;
  logic [TW-1:0]         timer;
  tx_state_e             state;

  sync_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rxdReady_i),
    .pop   (rxPop_i),
    .wdata (rxdData_i),
    .rdata (rxData_o),
    .count (rxCount_o),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (txPush_i),
    .pop   (tx_pop),
    .wdata (txData_i),
    .rdata (tx_head),
    .count (txCount_o),
    .full  (txFull_o),
    .empty (tx_empty)
  );

  assign rxValid_o = !rx_empty;
  assign int_o     = !rx_empty;

  // A pop on a full FIFO makes room, so only a lone push overflows.
  assign ovf_set = rxdReady_i && rx_full && !rxPop_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rxOverflow_o <= 1'b0;
    else if (ovf_set)    rxOverflow_o <= 1'b1;
    else if (ovfClear_i) rxOverflow_o <= 1'b0;
  end

  // Head is latched and popped on the edge that enters START.
  assign tx_pop = (state == ST_IDLE) && !tx_empty && !txdBusy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      txdStart_o <= 1'b0;
      txdData_o  <= '0;
      timer      <= '0;
    end else begin
      txdStart_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tx_pop) begin
            state      <= ST_START;
            txdStart_o <= 1'b1;
            txdData_o  <= tx_head;
          end
        end
        ST_START: begin
          state <= ST_WAIT_BUSY;
          timer <= '0;
        end
        ST_WAIT_BUSY: begin
          if (txdBusy_i)
            state <= ST_WAIT_DONE;
          else if (timer == TW'(BUSY_TIMEOUT - 1))
            state <= ST_IDLE;
          else
            timer <= timer + 1'b1;
        end
        ST_WAIT_DONE: begin
          if (!txdBusy_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
